// File: rtl/fazyrv_cmp_seq_pkg.sv
// ----------------------------------------------------------------------------
// fazyrv_cmp_seq_pkg
// Shared core header for the chunked compare sequencer. It holds the control
// FSM state encodings, the state enum built on them, and a helper that sizes
// the chunk counter.
// ----------------------------------------------------------------------------
package fazyrv_cmp_seq_pkg;

  // Compare sequencer FSM encodings, kept beside the other control FSMs
  localparam logic [1:0] CMP_ST_IDLE = 2'd0;
  localparam logic [1:0] CMP_ST_RUN  = 2'd1;
  localparam logic [1:0] CMP_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = CMP_ST_IDLE,
    ST_RUN  = CMP_ST_RUN,
    ST_DONE = CMP_ST_DONE
  } cmp_state_e;

  // Chunk counter width: $clog2(nchunks), but never narrower than one bit
  function automatic int cnt_width(input int nchunks);
    if (nchunks > 1) begin
      return $clog2(nchunks);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/fazyrv_cmp.sv
// ----------------------------------------------------------------------------
// fazyrv_cmp
// Per-chunk magnitude comparator. It compares one CHUNKSIZE-wide chunk of A
// against the matching chunk of B. When inv_msb_i is set, it inverts the MSB
// of both chunks first. On the most significant chunk, that turns an unsigned
// compare into a two's-complement signed compare.
//
// Ports:
//   a_i        chunk of operand A
//   b_i        chunk of operand B
//   inv_msb_i  invert the chunk MSB of both operands (signed, final chunk)
//   lo_o       A chunk < B chunk
//   gr_o       A chunk > B chunk
// ----------------------------------------------------------------------------
module fazyrv_cmp #(
  parameter int CHUNKSIZE = 2
) (
  input  logic [CHUNKSIZE-1:0] a_i,
  input  logic [CHUNKSIZE-1:0] b_i,
  input  logic                 inv_msb_i,
  output logic                 lo_o,
  output logic                 gr_o
);

  logic [CHUNKSIZE-1:0] a_s;
  logic [CHUNKSIZE-1:0] b_s;

  // Flip the sign bit of both operands so that the unsigned compare orders them as signed
  always_comb begin
    a_s = a_i;
    b_s = b_i;
    a_s[CHUNKSIZE-1] = a_i[CHUNKSIZE-1] ^ inv_msb_i;
    b_s[CHUNKSIZE-1] = b_i[CHUNKSIZE-1] ^ inv_msb_i;
  end

  // Unsigned verdict on the (possibly sign-adjusted) chunk pair
  always_comb begin
    lo_o = (a_s < b_s);
    gr_o = (a_s > b_s);
  end

endmodule

// File: rtl/fazyrv_cmp_seq.sv
// ----------------------------------------------------------------------------
// fazyrv_cmp_seq
// Sequencer that runs a full-width compare over the chunked datapath.
// Operands arrive one CHUNKSIZE-wide chunk per accepted beat, starting with
// the LSB chunk. Each chunk that is not equal overwrites the running lower or
// greater verdict, so the most significant chunk that differs decides the
// result. The final chunk is compared with inverted MSBs when the compare is
// signed.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous reset, active high
//   start_i    begin a compare (honoured in IDLE/DONE, ignored in RUN)
//   signed_i   signed compare, sampled with an honoured start_i
//   vld_i      a_i/b_i carry a valid chunk
//   a_i, b_i   operand chunks
//   busy_o     compare in progress
//   last_o     next accepted beat is the final chunk
//   done_o     one-cycle result-valid pulse
//   lt_o/eq_o/gt_o  registered result flags, held until the next result
// ----------------------------------------------------------------------------
module fazyrv_cmp_seq
  import fazyrv_cmp_seq_pkg::*;
#(
  parameter int CHUNKSIZE = 2,
  parameter int WIDTH     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 vld_i,
  input  logic [CHUNKSIZE-1:0] a_i,
  input  logic [CHUNKSIZE-1:0] b_i,
  output logic                 busy_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic                 lt_o,
  output logic                 eq_o,
  output logic                 gt_o
);

  localparam int NCHUNKS = WIDTH / CHUNKSIZE;
  localparam int CNT_W   = cnt_width(NCHUNKS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  cmp_state_e       state_r;
  cmp_state_e       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             lo_r;
  logic             lo_s;
  logic             gr_r;
  logic             gr_s;
  logic             signed_r;
  logic             signed_s;
  logic             lt_r;
  logic             lt_s;
  logic             eq_r;
  logic             eq_s;
  logic             gt_r;
  logic             gt_s;
  logic             busy_r;
  logic             last_r;
  logic             done_r;

  logic             inv_msb_s;
  logic             chunk_lo_s;
  logic             chunk_gr_s;

  // MSB inversion only matters on the most significant chunk of a signed compare
  always_comb begin
    inv_msb_s = signed_r & (cnt_r == CNT_LAST);
  end

  fazyrv_cmp #(
    .CHUNKSIZE (CHUNKSIZE)
  ) u_cmp (
    .a_i       (a_i),
    .b_i       (b_i),
    .inv_msb_i (inv_msb_s),
    .lo_o      (chunk_lo_s),
    .gr_o      (chunk_gr_s)
  );

  // Next-state, accumulator and result computation
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    lo_s     = lo_r;
    gr_s     = gr_r;
    signed_s = signed_r;
    lt_s     = lt_r;
    eq_s     = eq_r;
    gt_s     = gt_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          // Fresh compare. Previous lt/eq/gt stay visible until it completes.
          state_s  = ST_RUN;
          cnt_s    = CNT_ZERO;
          lo_s     = 1'b0;
          gr_s     = 1'b0;
          signed_s = signed_i;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (vld_i) begin
          // A chunk that differs overrides whatever less significant chunks said
          if (chunk_lo_s) begin
            lo_s = 1'b1;
            gr_s = 1'b0;
          end else if (chunk_gr_s) begin
            lo_s = 1'b0;
            gr_s = 1'b1;
          end else begin
            lo_s = lo_r;
            gr_s = gr_r;
          end

          if (cnt_r == CNT_LAST) begin
            state_s = ST_DONE;
            cnt_s   = CNT_ZERO;
            lt_s    = lo_s;
            gt_s    = gr_s;
            eq_s    = ~lo_s & ~gr_s;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          // Stall: no beat this cycle, hold everything
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        lo_s    = 1'b0;
        gr_s    = 1'b0;
      end
    endcase
  end

  // State, accumulator and registered output flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      lo_r     <= 1'b0;
      gr_r     <= 1'b0;
      signed_r <= 1'b0;
      lt_r     <= 1'b0;
      eq_r     <= 1'b0;
      gt_r     <= 1'b0;
      busy_r   <= 1'b0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      lo_r     <= lo_s;
      gr_r     <= gr_s;
      signed_r <= signed_s;
      lt_r     <= lt_s;
      eq_r     <= eq_s;
      gt_r     <= gt_s;
      // Status flags are decoded from the next state so they line up with state_r
      busy_r   <= (state_s == ST_RUN);
      last_r   <= (state_s == ST_RUN) && (cnt_s == CNT_LAST);
      done_r   <= (state_s == ST_DONE);
    end
  end

  assign busy_o = busy_r;
  assign last_o = last_r;
  assign done_o = done_r;
  assign lt_o   = lt_r;
  assign eq_o   = eq_r;
  assign gt_o   = gt_r;

endmodule

// File: tb/tb_fazyrv_cmp_seq.sv
// ----------------------------------------------------------------------------
// tb_fazyrv_cmp_seq
// Directed bench for the chunked compare sequencer. It drives three builds:
// CHUNKSIZE=2 (main), CHUNKSIZE=1 and CHUNKSIZE=32.
// ----------------------------------------------------------------------------
module tb_fazyrv_cmp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s2_start, s2_signed, s2_vld;
  logic [1:0] s2_a, s2_b;
  logic       s2_busy, s2_last, s2_done, s2_lt, s2_eq, s2_gt;

  logic       s1_start, s1_signed, s1_vld;
  logic [0:0] s1_a, s1_b;
  logic       s1_busy, s1_last, s1_done, s1_lt, s1_eq, s1_gt;

  logic        s32_start, s32_signed, s32_vld;
  logic [31:0] s32_a, s32_b;
  logic        s32_busy, s32_last, s32_done, s32_lt, s32_eq, s32_gt;

  int checks = 0;
  int errors = 0;

  fazyrv_cmp_seq #(.CHUNKSIZE(2), .WIDTH(32)) u_d2 (
    .clk_i(clk), .rst_i(rst), .start_i(s2_start), .signed_i(s2_signed),
    .vld_i(s2_vld), .a_i(s2_a), .b_i(s2_b), .busy_o(s2_busy), .last_o(s2_last),
    .done_o(s2_done), .lt_o(s2_lt), .eq_o(s2_eq), .gt_o(s2_gt)
  );

  fazyrv_cmp_seq #(.CHUNKSIZE(1), .WIDTH(32)) u_d1 (
    .clk_i(clk), .rst_i(rst), .start_i(s1_start), .signed_i(s1_signed),
    .vld_i(s1_vld), .a_i(s1_a), .b_i(s1_b), .busy_o(s1_busy), .last_o(s1_last),
    .done_o(s1_done), .lt_o(s1_lt), .eq_o(s1_eq), .gt_o(s1_gt)
  );

  fazyrv_cmp_seq #(.CHUNKSIZE(32), .WIDTH(32)) u_d32 (
    .clk_i(clk), .rst_i(rst), .start_i(s32_start), .signed_i(s32_signed),
    .vld_i(s32_vld), .a_i(s32_a), .b_i(s32_b), .busy_o(s32_busy), .last_o(s32_last),
    .done_o(s32_done), .lt_o(s32_lt), .eq_o(s32_eq), .gt_o(s32_gt)
  );

  // Advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (s2_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", s2_busy); end
    checks++; if (s2_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", s2_last); end
    checks++; if (s2_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b000) begin errors++; $display("FAIL reset_flags2: got %b expected 000", {s2_lt, s2_eq, s2_gt}); end
    checks++; if ({s1_busy, s1_done, s1_lt, s1_eq, s1_gt} !== 5'b0) begin errors++; $display("FAIL reset_d1: got %b expected 00000", {s1_busy, s1_done, s1_lt, s1_eq, s1_gt}); end
    checks++; if ({s32_busy, s32_done, s32_lt, s32_eq, s32_gt} !== 5'b0) begin errors++; $display("FAIL reset_d32: got %b expected 00000", {s32_busy, s32_done, s32_lt, s32_eq, s32_gt}); end
    rst = 1'b0;
    step();
  endtask

  // Plan 1: 5 < 7 unsigned, 16 uninterrupted beats, done on the 17th edge
  task automatic test_unsigned_basic();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'd5;
    b = 32'd7;
    s2_signed = 1'b0; s2_start = 1'b1;
    s2_vld = 1'b1; s2_a = 2'd3; s2_b = 2'd0;   // junk beat alongside start must be ignored
    step();
    s2_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (s2_busy !== 1'b1) begin errors++; $display("FAIL basic_busy beat %0d: got %b expected 1", k, s2_busy); end
      checks++; if (s2_done !== 1'b0) begin errors++; $display("FAIL basic_early_done beat %0d: got %b expected 0", k, s2_done); end
      checks++; if (s2_last !== (k == 15)) begin errors++; $display("FAIL basic_last beat %0d: got %b expected %b", k, s2_last, (k == 15)); end
      s2_a = a[2*k +: 2]; s2_b = b[2*k +: 2]; s2_vld = 1'b1;
      step();
    end
    s2_vld = 1'b0;
    checks++; if (s2_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b100) begin errors++; $display("FAIL basic_result: got %b expected 100", {s2_lt, s2_eq, s2_gt}); end
    checks++; if (s2_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", s2_busy); end
    step();
    checks++; if (s2_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b100) begin errors++; $display("FAIL basic_hold: got %b expected 100", {s2_lt, s2_eq, s2_gt}); end
  endtask

  // Plan 2: 0xFFFFFFFF vs 1, signed gives lt, unsigned gives gt; MSB inversion only on beat 15
  task automatic test_signed_unsigned();
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  exp_flags;
    logic        sgn;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    for (int pass = 0; pass < 2; pass++) begin
      sgn = (pass == 0);
      exp_flags = sgn ? 3'b100 : 3'b001;
      s2_signed = sgn; s2_start = 1'b1; s2_vld = 1'b0;
      step();
      s2_start = 1'b0; s2_signed = 1'b0;
      for (int k = 0; k < 16; k++) begin
        s2_a = a[2*k +: 2]; s2_b = b[2*k +: 2]; s2_vld = 1'b1;
        #1;
        checks++; if (u_d2.inv_msb_s !== (sgn && (k == 15))) begin errors++; $display("FAIL sgn_inv_msb s=%0b beat %0d: got %b expected %b", sgn, k, u_d2.inv_msb_s, (sgn && (k == 15))); end
        step();
      end
      s2_vld = 1'b0;
      checks++; if (s2_done !== 1'b1) begin errors++; $display("FAIL sgn_done s=%0b: got %b expected 1", sgn, s2_done); end
      checks++; if ({s2_lt, s2_eq, s2_gt} !== exp_flags) begin errors++; $display("FAIL sgn_result s=%0b: got %b expected %b", sgn, {s2_lt, s2_eq, s2_gt}, exp_flags); end
      step();
    end
  endtask

  // Plan 3: equal signed operands with a stall before every beat
  task automatic test_stall();
    logic [31:0] a;
    a = 32'h8000_0001;
    s2_signed = 1'b1; s2_start = 1'b1; s2_vld = 1'b0;
    step();
    s2_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s2_vld = 1'b0; s2_a = 2'd0; s2_b = 2'd3;   // garbage data while stalled
      step();
      checks++; if (s2_busy !== 1'b1) begin errors++; $display("FAIL stall_busy beat %0d: got %b expected 1", k, s2_busy); end
      checks++; if (s2_done !== 1'b0) begin errors++; $display("FAIL stall_early_done beat %0d: got %b expected 0", k, s2_done); end
      s2_vld = 1'b1; s2_a = a[2*k +: 2]; s2_b = a[2*k +: 2];
      step();
    end
    s2_vld = 1'b0;
    checks++; if (s2_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b010) begin errors++; $display("FAIL stall_result: got %b expected 010", {s2_lt, s2_eq, s2_gt}); end
    step();
  endtask

  // Plan 4: high chunk gr overrides low-chunk lo; start_i mid-RUN is ignored
  task automatic test_override_midstart();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'h0001_0000;
    b = 32'h0000_FFFF;
    s2_signed = 1'b0; s2_start = 1'b1; s2_vld = 1'b0;
    step();
    s2_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s2_a = a[2*k +: 2]; s2_b = b[2*k +: 2]; s2_vld = 1'b1;
      s2_start = (k == 5); s2_signed = (k == 5);
      if (k == 8) begin
        checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b010) begin errors++; $display("FAIL ovr_prev_held: got %b expected 010", {s2_lt, s2_eq, s2_gt}); end
      end
      step();
      if (k < 15) begin
        checks++; if (s2_busy !== 1'b1) begin errors++; $display("FAIL ovr_busy beat %0d: got %b expected 1", k, s2_busy); end
      end
    end
    s2_vld = 1'b0; s2_start = 1'b0; s2_signed = 1'b0;
    checks++; if (s2_done !== 1'b1) begin errors++; $display("FAIL ovr_done: got %b expected 1", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b001) begin errors++; $display("FAIL ovr_result: got %b expected 001", {s2_lt, s2_eq, s2_gt}); end
    step();
  endtask

  // Plan 5: reset at beat 7 discards the compare; a following 3 == 3 compare is clean
  task automatic test_reset_mid();
    logic [31:0] a;
    logic [31:0] b;
    a = 32'd5;
    b = 32'd7;
    s2_signed = 1'b0; s2_start = 1'b1; s2_vld = 1'b0;
    step();
    s2_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      s2_a = a[2*k +: 2]; s2_b = b[2*k +: 2]; s2_vld = 1'b1;
      step();
    end
    rst = 1'b1; s2_a = 2'd1; s2_b = 2'd2;
    step();
    rst = 1'b0;
    checks++; if ({s2_busy, s2_last, s2_done} !== 3'b000) begin errors++; $display("FAIL rstmid_status: got %b expected 000", {s2_busy, s2_last, s2_done}); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {s2_lt, s2_eq, s2_gt}); end
    step();
    checks++; if ({s2_busy, s2_done} !== 2'b00) begin errors++; $display("FAIL rstmid_idle: got %b expected 00", {s2_busy, s2_done}); end
    s2_start = 1'b1; s2_vld = 1'b0;
    step();
    s2_start = 1'b0;
    a = 32'd3;
    for (int k = 0; k < 16; k++) begin
      s2_a = a[2*k +: 2]; s2_b = a[2*k +: 2]; s2_vld = 1'b1;
      step();
    end
    s2_vld = 1'b0;
    checks++; if (s2_done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b expected 1", s2_done); end
    checks++; if ({s2_lt, s2_eq, s2_gt} !== 3'b010) begin errors++; $display("FAIL rstmid_result: got %b expected 010", {s2_lt, s2_eq, s2_gt}); end
    step();
  endtask

  // Plan 6: CHUNKSIZE=1 and 32 builds, signed -1 vs 0, plus back-to-back start in DONE
  task automatic test_sweep();
    logic [31:0] a;
    a = 32'hFFFF_FFFF;
    s1_signed = 1'b1; s1_start = 1'b1; s1_vld = 1'b0;
    step();
    s1_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      s1_a = a[k]; s1_b = 1'b0; s1_vld = 1'b1;
      step();
    end
    s1_vld = 1'b0;
    checks++; if (s1_done !== 1'b1) begin errors++; $display("FAIL cs1_done: got %b expected 1", s1_done); end
    checks++; if ({s1_lt, s1_eq, s1_gt} !== 3'b100) begin errors++; $display("FAIL cs1_result: got %b expected 100", {s1_lt, s1_eq, s1_gt}); end

    s32_signed = 1'b1; s32_start = 1'b1; s32_vld = 1'b0;
    step();
    s32_start = 1'b0;
    checks++; if ({s32_busy, s32_last, s32_done} !== 3'b110) begin errors++; $display("FAIL cs32_run: got %b expected 110", {s32_busy, s32_last, s32_done}); end
    s32_a = 32'hFFFF_FFFF; s32_b = 32'h0; s32_vld = 1'b1;
    step();
    s32_vld = 1'b0;
    checks++; if (s32_done !== 1'b1) begin errors++; $display("FAIL cs32_done: got %b expected 1", s32_done); end
    checks++; if ({s32_lt, s32_eq, s32_gt} !== 3'b100) begin errors++; $display("FAIL cs32_result: got %b expected 100", {s32_lt, s32_eq, s32_gt}); end
    // Back-to-back: start in the DONE cycle, now unsigned
    s32_signed = 1'b0; s32_start = 1'b1;
    step();
    s32_start = 1'b0;
    checks++; if ({s32_busy, s32_done} !== 2'b10) begin errors++; $display("FAIL b2b_run: got %b expected 10", {s32_busy, s32_done}); end
    checks++; if ({s32_lt, s32_eq, s32_gt} !== 3'b100) begin errors++; $display("FAIL b2b_hold: got %b expected 100", {s32_lt, s32_eq, s32_gt}); end
    s32_vld = 1'b1;
    step();
    s32_vld = 1'b0;
    checks++; if (s32_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", s32_done); end
    checks++; if ({s32_lt, s32_eq, s32_gt} !== 3'b001) begin errors++; $display("FAIL b2b_result: got %b expected 001", {s32_lt, s32_eq, s32_gt}); end
    step();
    checks++; if ({s32_busy, s32_done} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", {s32_busy, s32_done}); end
  endtask

  initial begin
    rst = 1'b1;
    s2_start = 1'b0;  s2_signed = 1'b0;  s2_vld = 1'b0;  s2_a = 2'd0;  s2_b = 2'd0;
    s1_start = 1'b0;  s1_signed = 1'b0;  s1_vld = 1'b0;  s1_a = 1'b0;  s1_b = 1'b0;
    s32_start = 1'b0; s32_signed = 1'b0; s32_vld = 1'b0; s32_a = 32'd0; s32_b = 32'd0;
    test_reset();
    test_unsigned_basic();
    test_signed_unsigned();
    test_stall();
    test_override_midstart();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fazyrv_cmp_seq.md
Name: fazyrv_cmp_seq

Overview:
Sequencer that runs a full-width comparison (BLT/BGE/BLTU/BGEU/SLT/SLTU/BEQ/BNE) over the chunked datapath. Operands arrive one CHUNKSIZE-wide chunk per accepted beat, LSB chunk first. The block drives the per-chunk comparator, including MSB-inversion on the final chunk for signed compares. It accumulates the lower/greater verdict across chunks and presents registered lt/eq/gt flags with a done pulse to the control unit.

Parameters:
CHUNKSIZE, 2, width of one data chunk. Legal values: 1, 2, 4, 8, 16, 32. Must divide WIDTH.
WIDTH, 32, full operand width in bits.
NCHUNKS (localparam), WIDTH/CHUNKSIZE, number of beats per compare.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_i  in  1  synchronous reset, active-high.
start_i  in  1  begin a new compare; honoured in IDLE or DONE, ignored in RUN.
signed_i  in  1  signed compare; sampled only on an honoured start_i.
vld_i  in  1  a_i/b_i hold a valid chunk this cycle.
a_i  in  CHUNKSIZE  chunk of operand A.
b_i  in  CHUNKSIZE  chunk of operand B.
busy_o  out  1  high in RUN.
last_o  out  1  high in RUN when the chunk counter equals NCHUNKS-1.
done_o  out  1  one-cycle pulse: result valid.
lt_o  out  1  A < B.
eq_o  out  1  A == B.
gt_o  out  1  A > B.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_i=1, any state, including mid-compare): state=IDLE, cnt=0, lo_q=0, gr_q=0, signed_q=0. Outputs: busy_o=0, last_o=0, done_o=0, lt_o=0, eq_o=0, gt_o=0. A partially accumulated compare is discarded.
- IDLE/DONE with start_i=1:
  - go to RUN; cnt<=0; lo_q<=0; gr_q<=0; signed_q<=signed_i.
  - vld_i in the same cycle is ignored.
  - lt/eq/gt outputs keep their previous values until the new result completes.
- DONE with start_i=0: go to IDLE after one cycle.
- RUN, vld_i=0: hold all state (stall). There is no timeout.
- RUN, vld_i=1, beat accepted:
  - Chunk comparator inputs: a_i, b_i, inv_msb = signed_q & (cnt==NCHUNKS-1).
  - Chunk result lo: lo_q<=1, gr_q<=0.
  - Chunk result gr: lo_q<=0, gr_q<=1.
  - Chunk equal: lo_q and gr_q unchanged (the more significant chunk dominates).
  - cnt<=cnt+1 for cnt<NCHUNKS-1.
- Final beat (cnt==NCHUNKS-1 accepted):
  - go to DONE; cnt<=0.
  - Register lt_o/gt_o from the updated lo/gr value; eq_o = ~lt & ~gt.
  - done_o=1 during the DONE cycle only.
- Latency: done_o asserts exactly one cycle after the last accepted beat. Minimum start-to-done is NCHUNKS+1 cycles.
- Exactly one of lt_o/eq_o/gt_o is high after any completed compare.
- start_i asserted during RUN is ignored (no restart, no error).
- Back-to-back compares: start_i in the DONE cycle is honoured. done_o still pulses in that cycle.
- NCHUNKS==1: the first beat is also the last. inv_msb applies to that beat when signed_q=1.
- Counter width: $clog2(NCHUNKS), minimum 1 bit. There is no wrap beyond NCHUNKS-1.

Decomposition:
- State encoding localparams (IDLE/RUN/DONE) go in the shared core header, next to the other control FSM encodings.
- One sub-module instance: fazyrv_cmp (CHUNKSIZE passed through). It provides the per-chunk lo/gr results. The sequencer adds no compare logic of its own.

Test Plan:
1. CHUNKSIZE=2, unsigned, A=5, B=7, 16 beats back-to-back -> done_o on cycle 17 after start; lt=1, eq=0, gt=0.
2. CHUNKSIZE=2, A=0xFFFFFFFF, B=0x00000001:
   - signed -> lt=1.
   - unsigned -> gt=1.
   - Check inv_msb high only on beat 15.
3. A=B=0x80000001, signed, vld_i low on every other cycle -> eq=1; done_o exactly one cycle after the 16th accepted beat; busy_o high throughout.
4. A=0x00010000, B=0x0000FFFF, unsigned -> gt=1 (a high chunk overrides an earlier lo). Also assert start_i mid-RUN and confirm it is ignored.
5. Reset at beat 7 of a compare -> next cycle IDLE, all outputs 0. A new compare A=3, B=3 then yields eq=1.
6. Parameter sweep CHUNKSIZE=1 and 32, signed A=-1, B=0:
   - lt=1 in both builds.
   - CHUNKSIZE=32: done_o two cycles after start with a vld_i beat in cycle 1.
   - Back-to-back start in the DONE cycle is honoured.
